// File: rtl/vga_vram_arbiter_pkg.sv
// Raster geometry, frame-buffer constants and grant encodings
// shared by the VRAM arbiter and its write FIFO.
package vga_vram_arbiter_pkg;

  localparam int RESOL_X    = 640;
  localparam int RESOL_Y    = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 521;
  localparam int CELL_SHIFT = 2;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int FB_CELLS   = FB_W * FB_H;

  localparam logic [2:0] RGB_BLACK = 3'b000;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_DISP = 2'b01;
  localparam logic [1:0] GNT_CPU  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_CPU
  } gnt_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO buffering CPU cell writes (address + colour)
// until the arbiter finds a free RAM slot.
import vga_vram_arbiter_pkg::*;

module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 15,
  parameter int DW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wp_d  = wp_q + PW'(do_push);
    rp_d  = rp_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      addr_mem[wp_q] <= wr_addr_i;
      data_mem[wp_q] <= wr_data_i;
    end
  end

  assign rd_addr_o = addr_mem[rp_q];
  assign rd_data_o = data_mem[rp_q];

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port VRAM between VGA pixel fetch and a
// FIFO-buffered CPU write port; owns the RGB/sync output pipeline.
import vga_vram_arbiter_pkg::*;

module vga_vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPixelEnable,
  input  logic [9:0]        iCont_X,
  input  logic [9:0]        iCont_Y,
  input  logic              iH_Sync,
  input  logic              iV_Sync,
  input  logic              iWrValid,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrReady,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [DATA_W-1:0] oRamWData,
  input  logic [DATA_W-1:0] iRamRData,
  output logic [DATA_W-1:0] oRGB,
  output logic              oH_Sync,
  output logic              oV_Sync,
  output logic [1:0]        oGrant,
  output logic              oAddrErr
);

  gnt_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rgb_q;
  logic              hs_q;
  logic              vs_q;
  logic              err_q;

  logic              active;
  logic              disp_slot;
  logic              cpu_slot;
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] disp_addr;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_bad;
  logic              err_set;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [1:0]        grant;

  // Illegal counter values fall outside both bounds and blank.
  assign active = (iCont_X < 10'(RESOL_X)) &&
                  (iCont_Y < 10'(RESOL_Y)) &&
                  (iCont_X < 10'(H_TOTAL)) &&
                  (iCont_Y < 10'(V_TOTAL));

  assign row_w     = ADDR_W'(iCont_Y >> CELL_SHIFT);
  assign col_w     = ADDR_W'(iCont_X >> CELL_SHIFT);
  assign disp_addr = row_w * ADDR_W'(FB_W) + col_w;

  assign disp_slot = !Reset && iPixelEnable && active;
  assign cpu_slot  = !Reset && !disp_slot && !empty;

  assign oWrReady = !full;
  assign push     = iWrValid && oWrReady && !Reset;
  assign head_bad = (head_addr >= ADDR_W'(FB_CELLS));

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_fifo (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .push_i    (push),
    .pop_i     (pop),
    .wr_addr_i (iWrAddr),
    .wr_data_i (iWrData),
    .rd_addr_o (head_addr),
    .rd_data_o (head_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    state_d = ST_IDLE;
    unique case (1'b1)
      disp_slot: state_d = ST_DISP;
      cpu_slot:  state_d = ST_CPU;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    pop       = 1'b0;
    err_set   = 1'b0;
    grant     = GNT_NONE;
    unique case (state_d)
      ST_DISP: begin
        ram_addr = disp_addr;
        grant    = GNT_DISP;
      end
      ST_CPU: begin
        pop       = 1'b1;
        grant     = GNT_CPU;
        ram_addr  = head_addr;
        ram_wdata = head_data;
        ram_we    = !head_bad;
        err_set   = head_bad;
      end
      default: ;
    endcase
  end

  // The read issued in a DISP cycle returns during the next cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= ram_addr;
      if (state_q == ST_DISP) rdata_q <= iRamRData;
      if (iPixelEnable) begin
        rgb_q <= active ? rdata_q : DATA_W'(RGB_BLACK);
        hs_q  <= iH_Sync;
        vs_q  <= iV_Sync;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign oRamAddr  = ram_addr;
  assign oRamWe    = ram_we;
  assign oRamWData = ram_wdata;
  assign oGrant    = grant;
  assign oRGB      = rgb_q;
  assign oH_Sync   = hs_q;
  assign oV_Sync   = vs_q;
  assign oAddrErr  = err_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural
// single-port RAM (1-cycle read latency).
module tb_vga_vram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iPixelEnable;
  logic [9:0]  iCont_X;
  logic [9:0]  iCont_Y;
  logic        iH_Sync;
  logic        iV_Sync;
  logic        iWrValid;
  logic [14:0] iWrAddr;
  logic [2:0]  iWrData;
  logic        oWrReady;
  logic [14:0] oRamAddr;
  logic        oRamWe;
  logic [2:0]  oRamWData;
  logic [2:0]  iRamRData;
  logic [2:0]  oRGB;
  logic        oH_Sync;
  logic        oV_Sync;
  logic [1:0]  oGrant;
  logic        oAddrErr;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] mem [19200];

  always #10 Clock = ~Clock;

  vga_vram_arbiter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPixelEnable (iPixelEnable),
    .iCont_X      (iCont_X),
    .iCont_Y      (iCont_Y),
    .iH_Sync      (iH_Sync),
    .iV_Sync      (iV_Sync),
    .iWrValid     (iWrValid),
    .iWrAddr      (iWrAddr),
    .iWrData      (iWrData),
    .oWrReady     (oWrReady),
    .oRamAddr     (oRamAddr),
    .oRamWe       (oRamWe),
    .oRamWData    (oRamWData),
    .iRamRData    (iRamRData),
    .oRGB         (oRGB),
    .oH_Sync      (oH_Sync),
    .oV_Sync      (oV_Sync),
    .oGrant       (oGrant),
    .oAddrErr     (oAddrErr)
  );

  // Read-before-write RAM model.
  always @(posedge Clock) begin
    if (oRamAddr < 15'd19200) iRamRData <= mem[oRamAddr];
    else iRamRData <= 3'd0;
    if (oRamWe && oRamAddr < 15'd19200) mem[oRamAddr] = oRamWData;
  end

  typedef struct {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    int         exp_addr;
    int         exp_gnt;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic pe, input int x, input int y);
    @(negedge Clock);
    iPixelEnable = pe;
    iCont_X = 10'(x);
    iCont_Y = 10'(y);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      Reset = 1'b1;
    end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  int idx, pidx, mcnt;
  logic pe_c, pushed, popped;

  initial begin
    for (int i = 0; i < 19200; i++) mem[i] = 3'd0;
    mem[0]    = 3'b101;
    mem[1]    = 3'b010;
    mem[1610] = 3'b111;

    tbl[0] = '{1'b1, 10'd0,    10'd0,    0,     1};
    tbl[1] = '{1'b1, 10'd13,   10'd9,    323,   1};
    tbl[2] = '{1'b0, 10'd13,   10'd9,    323,   0};
    tbl[3] = '{1'b1, 10'd639,  10'd479,  19199, 1};
    tbl[4] = '{1'b1, 10'd640,  10'd10,   19199, 0};
    tbl[5] = '{1'b1, 10'd1000, 10'd0,    19199, 0};
    tbl[6] = '{1'b1, 10'd5,    10'd500,  19199, 0};
    tbl[7] = '{1'b1, 10'd4,    10'd4,    161,   1};
    tbl[8] = '{1'b1, 10'd1023, 10'd1023, 161,   0};

    Reset = 1'b1;
    iPixelEnable = 1'b0;
    iCont_X = 10'd700;
    iCont_Y = 10'd10;
    iH_Sync = 1'b0;
    iV_Sync = 1'b0;
    iWrValid = 1'b1;
    iWrAddr = 15'd50;
    iWrData = 3'd7;

    // Reset state; writes offered during reset must be dropped.
    do_reset(3);
    iWrValid = 1'b0;
    #1;
    chk("rst_rgb", oRGB, 0);
    chk("rst_hs", oH_Sync, 1);
    chk("rst_vs", oV_Sync, 1);
    chk("rst_we", oRamWe, 0);
    chk("rst_addr", oRamAddr, 0);
    chk("rst_gnt", oGrant, 0);
    chk("rst_err", oAddrErr, 0);
    chk("rst_rdy", oWrReady, 1);
    drive(1'b0, 700, 10);
    chk("rst_fifo_empty", oGrant, 0);
    chk("rst_no_write", mem[50], 0);

    // Address / grant table with an empty FIFO.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].pe, int'(tbl[i].x), int'(tbl[i].y));
      chk($sformatf("tbl%0d_addr", i), oRamAddr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_gnt", i), oGrant, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_we", i), oRamWe, 0);
    end

    // Pixel pipeline: one tick of latency, blanking, sync.
    do_reset(1);
    drive(1'b1, 0, 0);
    chk("pix0_addr", oRamAddr, 0);
    chk("pix0_gnt", oGrant, 1);
    drive(1'b0, 0, 0);
    chk("pix0_rgb_reset", oRGB, 0);
    chk("pix0_hs", oH_Sync, 0);
    iH_Sync = 1'b1;
    drive(1'b1, 4, 0);
    chk("pix1_addr", oRamAddr, 1);
    drive(1'b0, 4, 0);
    chk("pix_rgb_cell0", oRGB, 5);
    chk("pix1_hs", oH_Sync, 1);
    drive(1'b1, 8, 0);
    drive(1'b0, 8, 0);
    chk("pix_rgb_cell1", oRGB, 2);
    drive(1'b1, 640, 10);
    chk("blank_we", oRamWe, 0);
    chk("blank_gnt", oGrant, 0);
    drive(1'b0, 640, 10);
    chk("blank_rgb", oRGB, 0);

    // Fill the FIFO while the display owns every cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      iPixelEnable = 1'b1;
      iCont_X = 10'd20;
      iCont_Y = 10'd20;
      iWrValid = 1'b1;
      iWrAddr = 15'(10 + i);
      iWrData = 3'(1 + i);
      #1;
      chk($sformatf("fill%0d_rdy", i), oWrReady, (i < 4) ? 1 : 0);
      chk($sformatf("fill%0d_gnt", i), oGrant, 1);
    end
    iWrValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 700, 10);
      chk($sformatf("drain%0d_gnt", i), oGrant, 2);
      chk($sformatf("drain%0d_we", i), oRamWe, 1);
      chk($sformatf("drain%0d_addr", i), oRamAddr, 10 + i);
      chk($sformatf("drain%0d_data", i), oRamWData, 1 + i);
    end
    drive(1'b0, 700, 10);
    chk("drain_done_gnt", oGrant, 0);
    chk("drain_hold_addr", oRamAddr, 13);
    chk("drain_rejected", mem[14], 0);

    // Active video: CPU writes only between pixel ticks.
    idx = 0;
    pidx = 0;
    mcnt = 0;
    for (int c = 0; c < 24; c++) begin
      pe_c = (c % 2 == 0);
      @(negedge Clock);
      iPixelEnable = pe_c;
      iCont_X = 10'(c * 4);
      iCont_Y = 10'd16;
      iWrValid = (idx < 8);
      iWrAddr = 15'(100 + idx);
      iWrData = 3'(idx) ^ 3'b101;
      #1;
      chk("act_rdy", oWrReady, (mcnt < 4) ? 1 : 0);
      if (pe_c) begin
        chk("act_tick_gnt", oGrant, 1);
        chk("act_tick_we", oRamWe, 0);
        chk("act_tick_addr", oRamAddr, 640 + c);
      end else begin
        chk("act_slot_gnt", oGrant, (mcnt > 0) ? 2 : 0);
        if (mcnt > 0) begin
          chk("act_slot_we", oRamWe, 1);
          chk("act_slot_addr", oRamAddr, 100 + pidx);
        end
      end
      pushed = iWrValid && (mcnt < 4);
      popped = !pe_c && (mcnt > 0);
      if (pushed) idx++;
      if (popped) pidx++;
      mcnt = mcnt + int'(pushed) - int'(popped);
    end
    iWrValid = 1'b0;
    chk("act_all_pushed", idx, 8);
    chk("act_all_popped", pidx, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("act_cell%0d", 100 + i), mem[100 + i],
          int'(3'(i) ^ 3'b101));
    end

    // Out-of-range address is dropped and flagged.
    @(negedge Clock);
    iPixelEnable = 1'b0;
    iCont_X = 10'd700;
    iWrValid = 1'b1;
    iWrAddr = 15'd19200;
    iWrData = 3'd7;
    #1;
    chk("oob_push_gnt", oGrant, 0);
    @(negedge Clock);
    iWrAddr = 15'd5;
    iWrData = 3'd6;
    #1;
    chk("oob_pop_gnt", oGrant, 2);
    chk("oob_pop_we", oRamWe, 0);
    chk("oob_err_before", oAddrErr, 0);
    @(negedge Clock);
    iWrValid = 1'b0;
    #1;
    chk("oob_next_gnt", oGrant, 2);
    chk("oob_next_we", oRamWe, 1);
    chk("oob_next_addr", oRamAddr, 5);
    chk("oob_err_set", oAddrErr, 1);
    drive(1'b0, 700, 10);
    drive(1'b0, 700, 10);
    chk("oob_err_sticky", oAddrErr, 1);
    chk("oob_cell5", mem[5], 6);

    // Reset mid-line with three writes still queued.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      iPixelEnable = 1'b1;
      iCont_X = 10'd40;
      iCont_Y = 10'd40;
      iWrValid = (i < 3);
      iWrAddr = 15'(200 + i);
      iWrData = 3'd3;
      #1;
    end
    iWrValid = 1'b0;
    chk("pre_rst_rgb", oRGB, 7);
    chk("pre_rst_err", oAddrErr, 1);
    do_reset(1);
    iPixelEnable = 1'b0;
    iCont_X = 10'd700;
    iCont_Y = 10'd10;
    #1;
    chk("mid_rst_rgb", oRGB, 0);
    chk("mid_rst_err", oAddrErr, 0);
    chk("mid_rst_rdy", oWrReady, 1);
    chk("mid_rst_gnt", oGrant, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 700, 10);
      chk("mid_rst_no_cpu", oGrant, 0);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_cell%0d", 200 + i), mem[200 + i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
